// File: rtl/k2_out_capture.sv
// Capture FIFO behind the K2 output register: records {pc, value} on every RO load
// and lets a valid/ready consumer drain it; overruns are flagged and counted, never stalled.
module k2_out_capture #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ro_we,
  input  logic [7:0]       reg_o,
  input  logic [3:0]       pc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [7:0]       m_data,
  output logic [3:0]       m_pc,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic [7:0]       drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [11:0]      mem [DEPTH];
  logic [AW-1:0]    wp_reg, wp_next;
  logic [AW-1:0]    rp_reg, rp_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic [7:0]       drop_cnt_reg, drop_cnt_next;

  logic pop;
  logic push_ok;
  logic drop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign m_valid = ~empty;
  assign m_data  = mem[rp_reg][7:0];
  assign m_pc    = mem[rp_reg][11:8];

  assign count    = count_reg;
  assign overflow = overflow_reg;
  assign drop_cnt = drop_cnt_reg;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop     = m_valid & m_ready;
  assign push_ok = ro_we & (~full | pop);
  assign drop    = ro_we & ~push_ok;

  always_comb begin
    wp_next       = wp_reg;
    rp_next       = rp_reg;
    count_next    = count_reg + CNT_W'(push_ok) - CNT_W'(pop);
    overflow_next = overflow_reg;
    drop_cnt_next = drop_cnt_reg;
    if (push_ok) wp_next = wp_reg + AW'(1);
    if (pop)     rp_next = rp_reg + AW'(1);
    // A drop in the same cycle as a clear counts as the first drop after the clear.
    if (drop) begin
      overflow_next = 1'b1;
      if (clr_ovf)
        drop_cnt_next = 8'd1;
      else if (drop_cnt_reg != 8'hFF)
        drop_cnt_next = drop_cnt_reg + 8'd1;
    end else if (clr_ovf) begin
      overflow_next = 1'b0;
      drop_cnt_next = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_reg       <= '0;
      rp_reg       <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= 8'd0;
    end else begin
      wp_reg       <= wp_next;
      rp_reg       <= rp_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      drop_cnt_reg <= drop_cnt_next;
    end
  end

  // Storage is not reset; reset only rewinds the pointers.
  always_ff @(posedge clk) begin
    if (!reset && push_ok)
      mem[wp_reg] <= {pc, reg_o};
  end

endmodule

// File: tb/tb_k2_out_capture.sv
// Directed bench for k2_out_capture: ordered capture, overflow, full push/pop,
// wrap-around, drop saturation, reset, and a K2-style OUT sequence.
module tb_k2_out_capture;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ro_we = 1'b0;
  logic [7:0] reg_o = 8'd0;
  logic [3:0] pc = 4'd0;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic [3:0] m_pc;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       clr_ovf = 1'b0;
  logic [7:0] drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  k2_out_capture #(.DEPTH(8)) dut (
    .clk(clk), .reset(reset), .ro_we(ro_we), .reg_o(reg_o), .pc(pc),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_pc(m_pc),
    .count(count), .full(full), .empty(empty), .overflow(overflow),
    .clr_ovf(clr_ovf), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  logic [7:0] prog_val [6];
  logic [3:0] prog_pc  [6];

  initial begin
    int idx;
    int got;
    prog_val = '{8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13};
    prog_pc  = '{4'd2, 4'd4, 4'd6, 4'd9, 4'd11, 4'd14};

    // Reset state
    tick();
    reset = 1'b0;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_valid", m_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_cnt, 0);

    // Three ordered captures, then drain
    ro_we = 1'b1; reg_o = 8'h11; pc = 4'd2; tick();
    check("lat_valid", m_valid, 1);
    check("lat_data", m_data, 8'h11);
    reg_o = 8'h22; pc = 4'd3; tick();
    reg_o = 8'h33; pc = 4'd4; tick();
    ro_we = 1'b0;
    check("p3_count", count, 3);
    check("p3_data", m_data, 8'h11);
    check("p3_pc", m_pc, 2);
    m_ready = 1'b1;
    check("pop0_data", m_data, 8'h11); tick();
    check("pop1_data", m_data, 8'h22);
    check("pop1_pc", m_pc, 3); tick();
    check("pop2_data", m_data, 8'h33);
    check("pop2_pc", m_pc, 4); tick();
    m_ready = 1'b0;
    check("pop_empty", empty, 1);
    check("pop_valid", m_valid, 0);

    // Fill and overflow: 10 pushes into 8 entries
    for (int i = 0; i < 10; i++) begin
      ro_we = 1'b1; reg_o = 8'(i); pc = 4'(i);
      tick();
      if (i == 7) begin
        check("fill_full", full, 1);
        check("fill_ovf0", overflow, 0);
      end
    end
    ro_we = 1'b0;
    check("ovf_set", overflow, 1);
    check("ovf_drop2", drop_cnt, 2);
    check("ovf_count", count, 8);

    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    check("clr_ovf", overflow, 0);
    check("clr_drop", drop_cnt, 0);
    check("clr_count", count, 8);

    // Full with simultaneous push and pop
    ro_we = 1'b1; reg_o = 8'hAA; pc = 4'hA; m_ready = 1'b1;
    check("fpp_popped", m_data, 0);
    tick();
    ro_we = 1'b0; m_ready = 1'b0;
    check("fpp_count", count, 8);
    check("fpp_full", full, 1);
    check("fpp_ovf", overflow, 0);
    check("fpp_drop", drop_cnt, 0);
    m_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      check("drain_data", m_data, i);
      tick();
    end
    check("drain_tail", m_data, 8'hAA);
    check("drain_tail_pc", m_pc, 4'hA);
    tick();
    m_ready = 1'b0;
    check("drain_empty", empty, 1);

    // Wrap-around with concurrent push/pop
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ro_we = 1'b1; reg_o = 8'(i); pc = 4'(i);
      tick();
      check("wrap_data", m_data, i);
      check("wrap_pc", m_pc, i & 15);
      check("wrap_count", count, 1);
    end
    ro_we = 1'b0;
    tick();
    m_ready = 1'b0;
    check("wrap_empty", empty, 1);

    // Drop saturation
    for (int i = 0; i < 308; i++) begin
      ro_we = 1'b1; reg_o = 8'(i); pc = 4'(i);
      tick();
    end
    check("sat_drop", drop_cnt, 255);
    check("sat_ovf", overflow, 1);
    check("sat_count", count, 8);
    clr_ovf = 1'b1; tick();
    check("clrdrop_ovf", overflow, 1);
    check("clrdrop_cnt", drop_cnt, 1);
    ro_we = 1'b0; tick(); clr_ovf = 1'b0;
    check("clr2_ovf", overflow, 0);
    check("clr2_drop", drop_cnt, 0);

    // Reset mid-drain
    m_ready = 1'b1; tick();
    check("mid_count", count, 7);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mrst_empty", empty, 1);
    check("mrst_valid", m_valid, 0);
    check("mrst_count", count, 0);
    check("mrst_full", full, 0);
    m_ready = 1'b0;

    // K2-style program emitting 1,2,3,5,8,13 from its OUT instructions
    idx = 0;
    got = 0;
    for (int p = 0; p < 16; p++) begin
      pc = 4'(p);
      ro_we = (idx < 6) && (prog_pc[idx % 6] == 4'(p));
      reg_o = prog_val[idx % 6];
      m_ready = p[0];
      if (m_valid && m_ready && got < 6) begin
        check("prog_data", m_data, prog_val[got]);
        check("prog_pc", m_pc, prog_pc[got]);
        got++;
      end
      tick();
      if (ro_we) idx++;
    end
    ro_we = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 20 && got < 6; c++) begin
      if (m_valid) begin
        check("prog_data", m_data, prog_val[got]);
        check("prog_pc", m_pc, prog_pc[got]);
        got++;
      end
      tick();
    end
    m_ready = 1'b0;
    check("prog_count", got, 6);
    check("prog_empty", empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
